// File: rtl/inst_buffer_pkg.sv
// Shared types and helpers for the dual-read instruction buffer.
// Entry layout is {pc, inst}; the top packs its parameterised fields in the same order.
package inst_buffer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W   = 32;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_DATA_W-1:0] inst;
  } entry_t;

  localparam logic [1:0] DEQ_NONE = 2'd0;
  localparam logic [1:0] DEQ_ONE  = 2'd1;
  localparam logic [1:0] DEQ_TWO  = 2'd2;

  function automatic int cntW(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_buffer_ram.sv
// Entry storage: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset; validity is tracked by the occupancy count.
module inst_buffer_ram #(
  parameter int DEPTH = 32,
  parameter int W     = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr0_i,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  output logic [W-1:0]             rdata0_o,
  output logic [W-1:0]             rdata1_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_buffer.sv
// Show-ahead instruction buffer feeding a dual-issue decoder (0/1/2 retired per cycle).
// Optional INSTBUF_BYPASS_EN: incoming word is visible combinationally when fewer than two are stored.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rst_c,
  input  logic                   rdy,
  input  logic                   we_i,
  input  logic [DATA_W-1:0]      inst_i,
  input  logic [PC_W-1:0]        pc_i,
  input  logic [1:0]             deq_i,
  output logic [DATA_W-1:0]      inst0_o,
  output logic [PC_W-1:0]        pc0_o,
  output logic                   vld0_o,
  output logic [DATA_W-1:0]      inst1_o,
  output logic [PC_W-1:0]        pc1_o,
  output logic                   vld1_o,
  output logic [cntW(DEPTH)-1:0] count_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   afull_o,
  output logic                   ovf_o
);

  localparam int CNT_W   = cntW(DEPTH);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = PC_W + DATA_W;

  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   deqReq, avail, deqEff, deqStore;
  logic               bypassVis, bypassUsed, accept, storeWe, ramWe, illegal;
  logic [ENTRY_W-1:0] rdData0, rdData1;

  // A deq of 3 is clamped to 2; a bypassed word counts as available and,
  // if dequeued, is consumed without ever touching storage.
  always_comb begin
    deqReq = (deq_i == 2'd3) ? CNT_W'(DEQ_TWO) : CNT_W'(deq_i);
`ifdef INSTBUF_BYPASS_EN
    bypassVis = rdy && !rst_c && we_i && (count_q < CNT_W'(2));
`else
    bypassVis = 1'b0;
`endif
    avail      = count_q + CNT_W'(bypassVis);
    deqEff     = (deqReq > avail) ? avail : deqReq;
    bypassUsed = deqEff > count_q;
    deqStore   = deqEff - CNT_W'(bypassUsed);
    accept     = we_i && ((count_q - deqStore) < CNT_W'(DEPTH));
    storeWe    = accept && !bypassUsed;
    illegal    = (deq_i == 2'd3) || (deqReq > avail) || (we_i && !accept);
    ramWe      = rdy && !rst_c && storeWe;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (rdy) begin
      if (rst_c) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        head_d  = head_q + PTR_W'(deqStore);
        tail_d  = tail_q + PTR_W'(storeWe);
        count_d = count_q + CNT_W'(storeWe) - deqStore;
        ovf_d   = ovf_q | illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  inst_buffer_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ram (
    .clk_i    (clk),
    .we_i     (ramWe),
    .waddr_i  (tail_q),
    .wdata_i  ({pc_i, inst_i}),
    .raddr0_i (head_q),
    .raddr1_i (head_q + PTR_W'(1)),
    .rdata0_o (rdData0),
    .rdata1_o (rdData1)
  );

  // Invalid slots always drive zero rather than stale storage.
  always_comb begin
    vld0_o  = 1'b0;
    vld1_o  = 1'b0;
    pc0_o   = '0;
    inst0_o = '0;
    pc1_o   = '0;
    inst1_o = '0;
    if (count_q != '0) begin
      vld0_o           = 1'b1;
      {pc0_o, inst0_o} = rdData0;
    end else if (bypassVis) begin
      vld0_o           = 1'b1;
      {pc0_o, inst0_o} = {pc_i, inst_i};
    end
    if (count_q >= CNT_W'(2)) begin
      vld1_o           = 1'b1;
      {pc1_o, inst1_o} = rdData1;
    end else if (bypassVis && (count_q == CNT_W'(1))) begin
      vld1_o           = 1'b1;
      {pc1_o, inst1_o} = {pc_i, inst_i};
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign afull_o = (count_q >= CNT_W'(AFULL_TH));
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer (DEPTH=8) against a queue-based reference model.
// Directed test-plan sequences followed by randomized traffic and an asynchronous mid-run reset.
module tb_inst_buffer;

  localparam int DEPTH = 8;
  localparam int AFT   = 6;

  logic        clk = 1'b0;
  logic        rst, rstC, rdy, we;
  logic [1:0]  deq;
  logic [31:0] instIn, pcIn;
  logic [31:0] inst0, pc0, inst1, pc1;
  logic        vld0, vld1, empty, full, afull, ovf;
  logic [3:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        model[$];
  bit          ovfModel;
  int          testsRun;
  int          failCount;
  logic [31:0] nextPc;

  always #5 clk = ~clk;

  inst_buffer #(
    .DEPTH    (DEPTH),
    .DATA_W   (32),
    .PC_W     (32),
    .AFULL_TH (AFT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rst_c   (rstC),
    .rdy     (rdy),
    .we_i    (we),
    .inst_i  (instIn),
    .pc_i    (pcIn),
    .deq_i   (deq),
    .inst0_o (inst0),
    .pc0_o   (pc0),
    .vld0_o  (vld0),
    .inst1_o (inst1),
    .pc1_o   (pc1),
    .vld1_o  (vld1),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full),
    .afull_o (afull),
    .ovf_o   (ovf)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Expected outputs follow directly from the queue contents (plus the bypassed word if enabled).
  task automatic checkAll();
    int          n;
    logic        ev0, ev1;
    logic [31:0] ep0, ei0, ep1, ei1;
    n   = model.size();
    ev0 = (n >= 1);
    ev1 = (n >= 2);
    ep0 = ev0 ? model[0].pc   : 32'h0;
    ei0 = ev0 ? model[0].inst : 32'h0;
    ep1 = ev1 ? model[1].pc   : 32'h0;
    ei1 = ev1 ? model[1].inst : 32'h0;
`ifdef INSTBUF_BYPASS_EN
    if (rdy && !rstC && we && n == 0) begin
      ev0 = 1'b1; ep0 = pcIn; ei0 = instIn;
    end
    if (rdy && !rstC && we && n == 1) begin
      ev1 = 1'b1; ep1 = pcIn; ei1 = instIn;
    end
`endif
    checkOutput("count", 64'(count), 64'(n));
    checkOutput("empty", 64'(empty), 64'(n == 0));
    checkOutput("full",  64'(full),  64'(n == DEPTH));
    checkOutput("afull", 64'(afull), 64'(n >= AFT));
    checkOutput("ovf",   64'(ovf),   64'(ovfModel));
    checkOutput("vld0",  64'(vld0),  64'(ev0));
    checkOutput("vld1",  64'(vld1),  64'(ev1));
    checkOutput("slot0", {pc0, inst0}, {ep0, ei0});
    checkOutput("slot1", {pc1, inst1}, {ep1, ei1});
  endtask

  task automatic modelStep();
    int   dr, avail, d;
    bit   byp;
    ent_t e;
    if (!rdy) return;
    if (rstC) begin
      model.delete();
      return;
    end
    e.pc   = pcIn;
    e.inst = instIn;
    dr     = (deq == 2'd3) ? 2 : int'(deq);
    byp    = 1'b0;
`ifdef INSTBUF_BYPASS_EN
    byp = we && (model.size() < 2);
`endif
    avail = model.size() + (byp ? 1 : 0);
    if (deq == 2'd3 || dr > avail) ovfModel = 1'b1;
    d = (dr < avail) ? dr : avail;
    if (byp) begin
      model.push_back(e);
      repeat (d) void'(model.pop_front());
    end else begin
      repeat (d) void'(model.pop_front());
      if (we) begin
        if (model.size() < DEPTH) model.push_back(e);
        else ovfModel = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input bit w, input logic [1:0] d, input bit rc, input bit ry);
    @(negedge clk);
    we     = w;
    deq    = d;
    rstC   = rc;
    rdy    = ry;
    pcIn   = nextPc;
    instIn = $urandom;
    #1 checkAll();
    @(posedge clk);
    modelStep();
    if (w) nextPc += 32'h4;
  endtask

  initial begin
    int r;
    logic [1:0] dq;
    testsRun  = 0;
    failCount = 0;
    ovfModel  = 1'b0;
    nextPc    = 32'h0;
    rst = 1'b0; rstC = 1'b0; rdy = 1'b1; we = 1'b0; deq = 2'd0;
    pcIn = '0; instIn = '0;
    #12 checkAll();
    @(negedge clk) rst = 1'b1;

    repeat (3) applyStimulus(1, 2'd0, 0, 1);
    applyStimulus(1, 2'd2, 0, 1);
    repeat (6) applyStimulus(1, 2'd0, 0, 1);
    applyStimulus(1, 2'd0, 0, 1);
    applyStimulus(1, 2'd1, 0, 1);
    repeat (20) applyStimulus(1, 2'd1, 0, 1);
    repeat (3) applyStimulus(0, 2'd1, 0, 1);
    applyStimulus(1, 2'd2, 1, 1);
    repeat (2) applyStimulus(1, 2'd0, 0, 1);
    repeat (3) applyStimulus(1, 2'd1, 0, 0);
    applyStimulus(0, 2'd0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      dq = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      applyStimulus($urandom_range(0, 3) != 0, dq,
                    $urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0);
    end

    repeat (4) applyStimulus(1, 2'd0, 0, 1);
    @(negedge clk);
    we = 1'b0; deq = 2'd0; rstC = 1'b0; rdy = 1'b1;
    #2 rst = 1'b0;
    #1 model.delete();
    ovfModel = 1'b0;
    checkAll();
    @(negedge clk) rst = 1'b1;
    repeat (3) applyStimulus(1, 2'd0, 0, 1);
    applyStimulus(0, 2'd0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Parametrised instruction buffer between the fetch unit and a dual-issue decoder: accepts one fetched instruction/PC pair per cycle and presents the two oldest entries in show-ahead form, so decode can retire 0, 1 or 2 per cycle. It adds depth, width and count parameters, an occupancy count, an almost-full threshold, dual-entry dequeue and overflow detection. It sits after instruction fetch and is flushed by the branch-mispredict clear.

## Interface
- DEPTH, 32: number of entries; power of two, at least 4.
- DATA_W, 32: instruction width.
- PC_W, 32: PC width.
- AFULL_TH, DEPTH-2: count at or above which `afull_o` is asserted.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rst_c  in  1  synchronous pipeline clear (flush); active-high.
- rdy  in  1  global stall; 0 freezes all state.
- we_i  in  1  enqueue request.
- inst_i / pc_i  in  DATA_W / PC_W  enqueued instruction and PC.
- deq_i  in  2  entries retired this cycle (0, 1 or 2; 3 is illegal).
- inst0_o, pc0_o, vld0_o  out  DATA_W, PC_W, 1  oldest entry.
- inst1_o, pc1_o, vld1_o  out  DATA_W, PC_W, 1  second-oldest entry.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- empty_o / full_o / afull_o  out  1  count==0 / count==DEPTH / count>=AFULL_TH.
- ovf_o  out  1  sticky error flag: illegal write or dequeue was seen.

## Operation
- Circular storage uses head and tail pointers of width $clog2(DEPTH); pointers wrap naturally modulo DEPTH. `count` is held in a separate register.
- Effective dequeue: `d = min(deq_i, count)`, with deq_i==3 treated as 2. If deq_i > count or deq_i==3, `ovf_o` is set.
- Write acceptance: the write is accepted when `we_i && (count - d < DEPTH)`. A write to a full buffer with no dequeue is dropped and sets `ovf_o`.
- Update: `head += d`, `tail += accepted`, `count += accepted - d`, all computed at CNT_W width.
- Output 0: `vld0_o = count>=1`. Output 1: `vld1_o = count>=2`.
- Invalid output slots drive zero on their inst/pc outputs. Outputs are never left at stale storage values.
- Status flags are combinational from `count`.
- `rst_c` and `rdy` priority:
  - `rst_c` (when `rdy=1`) clears head, tail and count to 0. It has priority over `we_i` and `deq_i` in the same cycle. It does not clear `ovf_o`.
  - With `rdy=0`, all inputs are ignored and state is unchanged.

## Timing
- Reset (rst=0) values: count_o=0, empty_o=1, full_o=0, afull_o=0, vld0_o=vld1_o=0, all inst/pc outputs 0, ovf_o=0. Storage contents are not reset.
- Write-to-visible latency is 1 cycle (without bypass). An entry written at edge N appears on output 0 or 1 after edge N.
- Dequeue is combinational-accept: with deq_i=k sampled at edge N, the next k entries are shown after N.
- Simultaneous write and dequeue when full (deq≥1): the write is accepted and count becomes DEPTH-d+1.
- With a single entry and deq_i=2: only 1 entry is removed, and ovf_o sets.
- Pointer wrap from DEPTH-1 to 0 is seamless; output 1 reads index head+1 modulo DEPTH.
- Reset asserted mid-operation: all state clears immediately (asynchronously); outputs reach reset values without a clock.

## Configuration
- Macro: `INSTBUF_BYPASS_EN`.
- Defined: when count==0 and we_i=1, inst_i/pc_i appear combinationally on output 0 with vld0_o=1 in the same cycle.
  - If deq_i≥1 that cycle, the entry is consumed and never stored; count stays 0.
  - When count==1, the incoming word likewise appears on output 1 with vld1_o=1.
- Undefined: no input-to-output combinational path; 1-cycle latency always.

## Structure
- Package `inst_buffer_pkg`:
  - `entry_t` struct {pc, inst}
  - `DEQ_NONE/DEQ_ONE/DEQ_TWO` encodings
  - CNT_W helper function
- Sub-module `inst_buffer_ram`: DEPTH x entry_t array, one synchronous write port and two asynchronous read ports (head, head+1).
- Pointer, count and flag logic live in the top module.

## Test plan
- Reset, then write 3 entries (pc 0x0, 0x4, 0x8) with deq_i=0 → count_o=3; output 0 pc 0x0 and output 1 pc 0x4, both valid.
- Dequeue 2 while writing pc 0xC → count_o=2; output 0 pc 0x8, output 1 pc 0xC.
- DEPTH=8:
  - fill 8 → full_o=1 and afull_o=1 (set from count 6).
  - Write with deq_i=0 → dropped, ovf_o=1, count_o stays 8.
  - Write with deq_i=1 → accepted, count_o stays 8.
- Stream 20 entries through DEPTH=8 with steady deq_i=1 → PCs emerge in order across the pointer wrap.
- With count 5, assert rst_c together with we_i=1 and deq_i=2 → count_o=0, empty_o=1, vld0_o=0; hold rdy=0 a few cycles and check nothing changes.
- With INSTBUF_BYPASS_EN defined, empty buffer, we_i=1 with pc 0x100 and deq_i=1 → vld0_o=1 and pc0_o=0x100 in the same cycle; count_o stays 0 next cycle.
